// File: rtl/rt_fragment_writer.sv
// Fragment stream sink: buffers render-core fragments in a FIFO and writes them
// sequentially into a linear framebuffer, checking stream length against the programmed count.
module rt_fragment_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] pixel_count,
    input  logic        frag_valid,
    output logic        frag_ready,
    input  logic        frag_last,
    input  logic [31:0] frag_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_last,
    output logic        busy,
    output logic        done,
    output logic        err_len
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [31:0]   base;
    logic [31:0]   total;
    logic [31:0]   in_count;
    logic [31:0]   out_count;
    logic [31:0]   in_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          pop;
    logic          final_frag;
    logic          burst_end;

    // Each entry carries the payload plus a flag marking the frame's final fragment.
    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [32:0]   head;

    assign fifo_full  = (occupancy == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (occupancy == '0);
    assign head       = fifo_mem[rd_ptr];

    assign frag_ready = (state == S_RUN) && !fifo_full;
    assign accept     = frag_valid && frag_ready;
    assign in_next    = in_count + 32'd1;
    assign final_frag = frag_last || (in_next == total);

    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign mem_valid  = busy && !fifo_empty;
    assign pop        = mem_valid && mem_ready;
    assign burst_end  = ((out_count & 32'(BURST_LEN - 1)) == 32'(BURST_LEN - 1));

    // Outputs are forced to zero while nothing is presented so stale FIFO words never leak.
    assign mem_data   = mem_valid ? head[31:0] : '0;
    assign mem_addr   = mem_valid ? (base + {out_count[29:0], 2'b00}) : '0;
    assign mem_last   = mem_valid && (burst_end || head[32]);

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= {final_frag, frag_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            base      <= '0;
            total     <= '0;
            in_count  <= '0;
            out_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            err_len   <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + AW'(1);
                in_count <= in_next;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_count <= out_count + 32'd1;
            end
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base      <= base_addr;
                        total     <= pixel_count;
                        in_count  <= '0;
                        out_count <= '0;
                        err_len   <= 1'b0;
                        state     <= (pixel_count == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept && final_frag) begin
                        state <= S_DRAIN;
                        if (frag_last != (in_next == total)) begin
                            err_len <= 1'b1;
                        end
                    end
                end
                // Leave on the edge that retires the last entry so done follows the final write by one cycle.
                S_DRAIN: begin
                    if (fifo_empty || (occupancy == (AW+1)'(1) && pop)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_fragment_writer.sv
// Randomized bench for rt_fragment_writer: drives frames, records every write and
// compares against a stream-level model of which fragments should land where.
module tb_rt_fragment_writer;

    localparam int DEPTH = 16;
    localparam int BURST = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] pixel_count = '0;
    logic        frag_valid = 1'b0;
    logic        frag_ready;
    logic        frag_last = 1'b0;
    logic [31:0] frag_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_last;
    logic        busy;
    logic        done;
    logic        err_len;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] frags [64];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic        wr_last [$];
    int acc_cnt, done_cnt, done_cyc, last_wr_cyc, first_acc_cyc, first_wr_cyc;
    int first_block, ready_low, hold_err;

    rt_fragment_writer #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BURST)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .pixel_count(pixel_count), .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_last(frag_last), .frag_data(frag_data), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_last(mem_last), .busy(busy), .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Number of fragments the sink should take: stops at the first last flag or at the count.
    function automatic int model_count(input int p, input int nfrag, input int last_idx);
        int k;
        k = nfrag;
        if (last_idx >= 0 && last_idx + 1 < k) k = last_idx + 1;
        if (p < k) k = p;
        return k;
    endfunction

    function automatic logic model_err(input int p, input int k, input int last_idx);
        return !(last_idx == k - 1 && k == p);
    endfunction

    function automatic logic model_last(input int i, input int k);
        return ((i % BURST) == BURST - 1) || (i == k - 1);
    endfunction

    // Runs one frame from a start pulse until a few cycles past done (or a cycle budget).
    task automatic run_frame(input int p, input logic [31:0] base, input int nfrag,
                             input int last_idx, input int stall, input bit rnd,
                             input int restart_at);
        int idx, cyc, tail;
        bit final_acc, prev_stall;
        logic [31:0] prev_addr, prev_data;
        logic prev_last;
        for (int i = 0; i < 64; i++) frags[i] = $urandom;
        wr_addr.delete(); wr_data.delete(); wr_last.delete();
        acc_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
        first_acc_cyc = -1; first_wr_cyc = -1; first_block = -1;
        ready_low = 0; hold_err = 0;
        idx = 0; cyc = 0; tail = 0; final_acc = 0; prev_stall = 0;
        prev_addr = '0; prev_data = '0; prev_last = 1'b0;
        start = 1'b1; base_addr = base; pixel_count = 32'(p);
        frag_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        while (tail < 4 && cyc < 2000) begin
            start       = (cyc == restart_at);
            base_addr   = start ? 32'hDEAD_0000 : base;
            pixel_count = start ? 32'd3 : 32'(p);
            frag_valid  = (idx < nfrag) && (!rnd || $urandom_range(0, 3) != 0);
            frag_data   = frags[idx < 64 ? idx : 0];
            frag_last   = (idx == last_idx);
            mem_ready   = (cyc >= stall) && (!rnd || $urandom_range(0, 2) != 0);
            @(negedge clk);
            if (prev_stall && (!mem_valid || mem_addr !== prev_addr ||
                               mem_data !== prev_data || mem_last !== prev_last))
                hold_err++;
            prev_stall = mem_valid && !mem_ready;
            prev_addr = mem_addr; prev_data = mem_data; prev_last = mem_last;
            if (busy && !frag_ready && !final_acc) begin
                ready_low++;
                if (first_block < 0) first_block = acc_cnt;
            end
            if (frag_valid && frag_ready) begin
                acc_cnt++;
                if (acc_cnt == 1) first_acc_cyc = cyc;
                if (frag_last || acc_cnt == p) final_acc = 1;
                idx++;
            end
            if (mem_valid && mem_ready) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_data);
                wr_last.push_back(mem_last);
                if (wr_addr.size() == 1) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0) tail++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; frag_valid = 1'b0; frag_last = 1'b0; mem_ready = 1'b0;
        if (cyc >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL frame_timeout p=%0d: done never seen within 2000 cycles", p);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({frag_ready, mem_valid, mem_last, busy, done, err_len} !== 6'b0 ||
            mem_addr !== 32'd0 || mem_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: flags=%b addr=%h data=%h, required all zero",
                     {frag_ready, mem_valid, mem_last, busy, done, err_len}, mem_addr, mem_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_normal_frame;
        int k;
        k = model_count(4, 4, 3);
        run_frame(4, 32'h1000, 4, 3, 0, 0, -1);
        vectors++;
        if (wr_addr.size() != k) begin
            miscompares++;
            $display("FAIL normal_write_count: got %0d required %0d", wr_addr.size(), k);
        end
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_addr[i] !== 32'h1000 + 32'(4 * i) || wr_data[i] !== frags[i] ||
                wr_last[i] !== model_last(i, k)) begin
                miscompares++;
                $display("FAIL normal_beat[%0d]: addr=%h data=%h last=%b required addr=%h data=%h last=%b",
                         i, wr_addr[i], wr_data[i], wr_last[i], 32'h1000 + 32'(4 * i), frags[i], model_last(i, k));
            end
        end
        vectors++;
        if (first_wr_cyc != first_acc_cyc + 1) begin
            miscompares++;
            $display("FAIL normal_latency: first write cycle %0d required %0d", first_wr_cyc, first_acc_cyc + 1);
        end
        vectors++;
        if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
            miscompares++;
            $display("FAIL normal_done: pulses=%0d at %0d required 1 at %0d", done_cnt, done_cyc, last_wr_cyc + 1);
        end
        vectors++;
        if (err_len !== model_err(4, k, 3) || ready_low != 0) begin
            miscompares++;
            $display("FAIL normal_err_ready: err_len=%b ready_low=%0d required err_len=0 ready_low=0", err_len, ready_low);
        end
    endtask

    task automatic test_backpressure;
        int k;
        k = model_count(40, 40, 39);
        run_frame(40, 32'h0004_0000, 40, 39, 30, 0, 5);
        vectors++;
        if (first_block != DEPTH) begin
            miscompares++;
            $display("FAIL bp_ready_drop: ready dropped after %0d accepts required %0d", first_block, DEPTH);
        end
        vectors++;
        if (wr_addr.size() != k || acc_cnt != k) begin
            miscompares++;
            $display("FAIL bp_counts: writes=%0d accepts=%0d required %0d", wr_addr.size(), acc_cnt, k);
        end
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_addr[i] !== 32'h0004_0000 + 32'(4 * i) || wr_data[i] !== frags[i]) begin
                miscompares++;
                $display("FAIL bp_beat[%0d]: addr=%h data=%h required addr=%h data=%h",
                         i, wr_addr[i], wr_data[i], 32'h0004_0000 + 32'(4 * i), frags[i]);
            end
        end
        vectors++;
        if (hold_err != 0 || done_cnt != 1 || err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold_done: hold_err=%0d done=%0d err_len=%b required 0,1,0", hold_err, done_cnt, err_len);
        end
    endtask

    task automatic test_early_last;
        int k;
        k = model_count(10, 10, 5);
        run_frame(10, 32'h0000_2000, 10, 5, 0, 1, -1);
        vectors++;
        if (acc_cnt != k || wr_addr.size() != k) begin
            miscompares++;
            $display("FAIL early_counts: accepts=%0d writes=%0d required %0d", acc_cnt, wr_addr.size(), k);
        end
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_data[i] !== frags[i] || wr_last[i] !== model_last(i, k)) begin
                miscompares++;
                $display("FAIL early_beat[%0d]: data=%h last=%b required data=%h last=%b",
                         i, wr_data[i], wr_last[i], frags[i], model_last(i, k));
            end
        end
        vectors++;
        if (err_len !== model_err(10, k, 5) || done_cnt != 1) begin
            miscompares++;
            $display("FAIL early_err_done: err_len=%b done=%0d required err_len=1 done=1", err_len, done_cnt);
        end
    endtask

    task automatic test_missing_last;
        int k;
        k = model_count(5, 7, -1);
        run_frame(5, 32'hFFFF_FFF8, 7, -1, 0, 1, -1);
        vectors++;
        if (acc_cnt != k || wr_addr.size() != k) begin
            miscompares++;
            $display("FAIL missing_counts: accepts=%0d writes=%0d required %0d", acc_cnt, wr_addr.size(), k);
        end
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_addr[i] !== 32'hFFFF_FFF8 + 32'(4 * i) || wr_data[i] !== frags[i]) begin
                miscompares++;
                $display("FAIL missing_beat[%0d]: addr=%h data=%h required addr=%h data=%h",
                         i, wr_addr[i], wr_data[i], 32'hFFFF_FFF8 + 32'(4 * i), frags[i]);
            end
        end
        vectors++;
        if (err_len !== model_err(5, k, -1) || done_cnt != 1) begin
            miscompares++;
            $display("FAIL missing_err_done: err_len=%b done=%0d required err_len=1 done=1", err_len, done_cnt);
        end
    endtask

    task automatic test_burst_marking;
        int k;
        k = model_count(20, 20, 19);
        run_frame(20, 32'h0000_8000, 20, 19, 0, 1, -1);
        vectors++;
        if (wr_addr.size() != k) begin
            miscompares++;
            $display("FAIL burst_count: writes=%0d required %0d", wr_addr.size(), k);
        end
        for (int i = 0; i < k && i < wr_addr.size(); i++) begin
            vectors++;
            if (wr_last[i] !== model_last(i, k) || wr_data[i] !== frags[i]) begin
                miscompares++;
                $display("FAIL burst_beat[%0d]: last=%b data=%h required last=%b data=%h",
                         i, wr_last[i], wr_data[i], model_last(i, k), frags[i]);
            end
        end
        vectors++;
        if (hold_err != 0 || done_cnt != 1 || err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_hold_done: hold_err=%0d done=%0d err_len=%b required 0,1,0", hold_err, done_cnt, err_len);
        end
    endtask

    task automatic test_reset_mid_frame;
        int seen_done;
        start = 1'b1; base_addr = 32'h2000; pixel_count = 32'd8;
        @(posedge clk); #1;
        start = 1'b0; mem_ready = 1'b0; frag_valid = 1'b1; frag_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frag_data = $urandom;
            @(posedge clk); #1;
        end
        frag_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({frag_ready, mem_valid, mem_last, busy, done, err_len} !== 6'b0 ||
            mem_addr !== 32'd0 || mem_data !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_async: flags=%b addr=%h data=%h, required all zero",
                     {frag_ready, mem_valid, mem_last, busy, done, err_len}, mem_addr, mem_data);
        end
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_valid || busy) seen_done++;
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: %0d cycles with activity after abort, required 0", seen_done);
        end
        @(posedge clk); #1;
        run_frame(0, 32'h3000, 0, -1, 0, 0, -1);
        vectors++;
        if (done_cnt != 1 || done_cyc != 0 || wr_addr.size() != 0 || err_len !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_count: done=%0d at %0d writes=%0d err_len=%b required 1 at 0, 0 writes, err_len=0",
                     done_cnt, done_cyc, wr_addr.size(), err_len);
        end
    endtask

    initial begin
        test_reset;
        test_normal_frame;
        test_backpressure;
        test_early_last;
        test_missing_last;
        test_burst_marking;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rt_fragment_writer.md
# rt_fragment_writer

Stream sink for the render core's fragment output: accepts 32-bit fragments over a valid/ready/last handshake, buffers them in a small FIFO, and writes them sequentially into a linear framebuffer through a single-beat valid/ready memory write port. It sits between the render core and the framebuffer memory. It checks that the stream length matches the programmed pixel count, and signals completion once every accepted fragment has been written.

## Interface
- FIFO_DEPTH, 16: fragment buffer entries; power of two, ≥2.
- BURST_LEN, 8: beats per burst group; power of two; only affects mem_last.
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE
- base_addr  in  32  framebuffer byte address of pixel 0, sampled on accepted start; word aligned
- pixel_count  in  32  expected fragment count (width×height, integer), sampled on accepted start
- frag_valid  in  1  fragment present
- frag_ready  out  1  sink can accept
- frag_last  in  1  final fragment of frame
- frag_data  in  32  fragment payload
- mem_valid  out  1  write request
- mem_ready  in  1  memory accepts write
- mem_addr  out  32  byte address
- mem_data  out  32  write data
- mem_last  out  1  final beat of a burst group or of the frame
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at frame completion
- err_len  out  1  sticky length-mismatch flag; cleared by accepted start

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch base_addr and pixel_count, clear in_count, out_count, err_len; go RUN. If pixel_count==0, go DONE instead.
- Accept = frag_valid && frag_ready; pushes frag_data into FIFO, in_count += 1.
- frag_ready = (state==RUN) && !fifo_full. Combinational from registered state/full only; no path from frag_valid.
- RUN → DRAIN on accept with frag_last, or on accept that makes in_count == pixel_count.
  - frag_last with in_count+1 ≠ pixel_count: set err_len.
  - in_count+1 == pixel_count without frag_last: set err_len.
- Write side (RUN or DRAIN): mem_valid = !fifo_empty; mem_data = FIFO head; mem_addr = base + 4×out_count (32-bit wrap). On mem_valid && mem_ready, pop FIFO, out_count += 1.
- mem_last = (out_count mod BURST_LEN == BURST_LEN−1) or (head is the frame's final fragment).
- DRAIN → DONE when FIFO empty. DONE: done=1 for one cycle, → IDLE.
- Fragments offered in IDLE/DRAIN/DONE are not accepted (frag_ready=0).
- Counters 32 bits.

## Timing
- Reset: state IDLE; frag_ready, mem_valid, mem_last, busy, done, err_len = 0; mem_addr, mem_data = 0; FIFO empty.
- Reset mid-frame: immediate abort, FIFO content discarded, no done.
- First-fragment latency: accepted at edge N → mem_valid high in cycle N+1.
- Full throughput: with mem_ready constantly 1, one fragment per cycle sustained, frag_ready never drops.
- FIFO full: frag_ready low the cycle after the FIFO reaches FIFO_DEPTH; a same-cycle pop does not re-enable ready until the next cycle.
- Push and pop in the same cycle: occupancy unchanged.
- mem_valid, mem_addr, mem_data, mem_last held stable while mem_valid && !mem_ready.
- done occurs one cycle after the last write handshake (DRAIN → DONE edge, pulse in DONE).
- start asserted in DONE or while busy: ignored.

## Test plan
- Normal frame: pixel_count=4, base 0x1000, 4 fragments, last on 4th, mem_ready=1 → writes 0x1000,0x1004,0x1008,0x100C in order; mem_last on beat 4; done pulse; err_len=0.
- Backpressure: pixel_count=40, mem_ready=0 for 30 cycles → frag_ready drops after 16 accepts; no data loss or duplication; all 40 written in order; done.
- Early last: pixel_count=10, frag_last on fragment 6 → 6 writes, err_len=1, done pulse, no further accepts.
- Missing last: pixel_count=5, 7 fragments without last → 5 accepted and written, err_len=1, fragments 6–7 never accepted.
- Burst marking: pixel_count=20, BURST_LEN=8 → mem_last on beats 8, 16, 20 only.
- Reset mid-frame and zero count: reset after 3 of 8 fragments → all outputs 0, IDLE; new start with pixel_count=0 → done one cycle later, no writes, err_len=0.
